// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, start-glitch rejection, 3-sample majority
// voting per bit, optional even/odd parity, and one-cycle status pulses after each frame.
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stop_Err
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;
   logic                  rx_meta;
   logic                  rx_s;
   logic [5:0]            edge_cnt;
   logic [CW-1:0]         bit_cnt;
   logic [2:0]            samples;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  par_flag;
   logic                  armed;
   logic                  par_en_r;
   logic                  par_typ_r;
   logic [5:0]            prescale_r;

   logic [5:0]            half;
   logic                  at_s0;
   logic                  at_s1;
   logic                  at_s2;
   logic                  at_dec;
   logic                  at_end;
   logic                  maj;
   logic [DATA_WIDTH:0]   shift_ext;
   logic [DATA_WIDTH-1:0] shift_next;

   // Sampling points are placed around the middle of the bit using the prescale latched at frame start.
   assign half       = {1'b0, prescale_r[5:1]};
   assign at_s0      = (edge_cnt == half - 6'd1);
   assign at_s1      = (edge_cnt == half);
   assign at_s2      = (edge_cnt == half + 6'd1);
   assign at_dec     = (edge_cnt == half + 6'd2);
   assign at_end     = (edge_cnt == prescale_r - 6'd1);
   assign maj        = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
   assign shift_ext  = {maj, shift_reg};
   assign shift_next = shift_ext[DATA_WIDTH:1];

   // Two-flop synchronizer; resets to the idle (high) line level so no false start follows reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX_IN;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM with bit timing, majority voting, parity tracking and registered status pulses.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         samples    <= '0;
         shift_reg  <= '0;
         par_flag   <= 1'b0;
         armed      <= 1'b1;
         par_en_r   <= 1'b0;
         par_typ_r  <= 1'b0;
         prescale_r <= '0;
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
         Par_Err    <= 1'b0;
         Stop_Err   <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         Par_Err    <= 1'b0;
         Stop_Err   <= 1'b0;

         if (state != IDLE) begin
            edge_cnt <= edge_cnt + 6'd1;
            if (at_s0) samples[0] <= rx_s;
            if (at_s1) samples[1] <= rx_s;
            if (at_s2) samples[2] <= rx_s;
         end

         case (state)
            IDLE: begin
               if (rx_s) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  state      <= START;
                  edge_cnt   <= '0;
                  bit_cnt    <= '0;
                  par_flag   <= 1'b0;
                  par_en_r   <= PAR_EN;
                  par_typ_r  <= PAR_TYP;
                  prescale_r <= Prescale;
               end
            end

            START: begin
               if (at_dec && maj) begin
                  state    <= IDLE;
                  edge_cnt <= '0;
               end else if (at_end) begin
                  state    <= DATA;
                  edge_cnt <= '0;
               end
            end

            DATA: begin
               if (at_dec) begin
                  shift_reg <= shift_next;
               end
               if (at_end) begin
                  edge_cnt <= '0;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= par_en_r ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            PARITY: begin
               if (at_dec) begin
                  par_flag <= maj ^ (^shift_reg) ^ par_typ_r;
               end
               if (at_end) begin
                  edge_cnt <= '0;
                  state    <= STOP;
               end
            end

            STOP: begin
               if (at_dec) begin
                  state    <= IDLE;
                  edge_cnt <= '0;
                  armed    <= maj;
                  Stop_Err <= ~maj;
                  Par_Err  <= par_flag;
                  if (maj && !par_flag) begin
                     Data_Valid <= 1'b1;
                     P_DATA     <= shift_reg;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               edge_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: serial frames driven bit by bit, output pulses counted and checked.
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Par_Err;
   logic       Stop_Err;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int dv_count = 0;
   int pe_count = 0;
   int se_count = 0;
   int conflict_count = 0;
   int last_dv_cycle = 0;
   int f_cycle = 0;
   int dv0, pe0, se0;
   logic [7:0] dv_log [0:31];

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .Par_Err    (Par_Err),
      .Stop_Err   (Stop_Err)
   );

   // Free-running clock, 10 ns period.
   always #5 CLK = ~CLK;

   // Count rising edges so latencies can be measured in cycles.
   always @(posedge CLK) cycle = cycle + 1;

   // Observe outputs on the falling edge: count pulse cycles and log received words.
   always @(negedge CLK) begin
      if (Data_Valid) begin
         if (dv_count < 32) dv_log[dv_count] = P_DATA;
         dv_count      = dv_count + 1;
         last_dv_cycle = cycle;
      end
      if (Par_Err) pe_count = pe_count + 1;
      if (Stop_Err) se_count = se_count + 1;
      if (Data_Valid && (Par_Err || Stop_Err)) conflict_count = conflict_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic sendBit(input logic b, input int presc);
      RX_IN = b;
      repeat (presc) @(negedge CLK);
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   task automatic snapshot();
      dv0 = dv_count;
      pe0 = pe_count;
      se0 = se_count;
   endtask

   // Drive one complete frame; parity and stop bits are given explicitly by the caller.
   task automatic applyStimulus(input logic [7:0] data, input int presc, input logic pen,
                                input logic ptyp, input logic par_bit, input logic stop_bit);
      Prescale = 6'(presc);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      f_cycle  = cycle + 1;
      sendBit(1'b0, presc);
      for (int i = 0; i < 8; i++) sendBit(data[i], presc);
      if (pen) sendBit(par_bit, presc);
      sendBit(stop_bit, presc);
   endtask

   initial begin
      RST      = 1'b1;
      RX_IN    = 1'b1;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      Prescale = 6'd8;
      repeat (4) @(negedge CLK);
      checkOutput("reset_pdata", 32'(P_DATA), 32'h0);
      checkOutput("reset_dv", 32'(Data_Valid), 32'h0);
      checkOutput("reset_pe", 32'(Par_Err), 32'h0);
      checkOutput("reset_se", 32'(Stop_Err), 32'h0);
      RST = 1'b0;
      idle(10);

      // Prescale 8, no parity, 0xA5, latency 81 cycles from F.
      snapshot();
      applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(24);
      checkOutput("a5_dv_count", 32'(dv_count - dv0), 32'd1);
      checkOutput("a5_pdata", 32'(P_DATA), 32'hA5);
      checkOutput("a5_latency", 32'(last_dv_cycle - f_cycle), 32'd81);
      checkOutput("a5_pe", 32'(pe_count - pe0), 32'd0);
      checkOutput("a5_se", 32'(se_count - se0), 32'd0);

      // Prescale 16, even parity, 0x3C with correct parity 0; latency 2+160+8+3.
      snapshot();
      applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(32);
      checkOutput("3c_dv_count", 32'(dv_count - dv0), 32'd1);
      checkOutput("3c_pdata", 32'(P_DATA), 32'h3C);
      checkOutput("3c_pe", 32'(pe_count - pe0), 32'd0);
      checkOutput("3c_latency", 32'(last_dv_cycle - f_cycle), 32'd173);

      // Same frame with parity bit flipped: parity error only, data held.
      snapshot();
      applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(32);
      checkOutput("parerr_pe", 32'(pe_count - pe0), 32'd1);
      checkOutput("parerr_dv", 32'(dv_count - dv0), 32'd0);
      checkOutput("parerr_se", 32'(se_count - se0), 32'd0);
      checkOutput("parerr_pdata", 32'(P_DATA), 32'h3C);

      // Odd parity, 0x07 has three ones so the correct parity bit is 0.
      snapshot();
      applyStimulus(8'h07, 8, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(24);
      checkOutput("odd_dv", 32'(dv_count - dv0), 32'd1);
      checkOutput("odd_pdata", 32'(P_DATA), 32'h07);
      snapshot();
      applyStimulus(8'h07, 8, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(24);
      checkOutput("odd_bad_pe", 32'(pe_count - pe0), 32'd1);
      checkOutput("odd_bad_dv", 32'(dv_count - dv0), 32'd0);

      // Prescale 32, stop bit forced low.
      snapshot();
      applyStimulus(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(64);
      checkOutput("stoperr_se", 32'(se_count - se0), 32'd1);
      checkOutput("stoperr_dv", 32'(dv_count - dv0), 32'd0);
      checkOutput("stoperr_pe", 32'(pe_count - pe0), 32'd0);
      checkOutput("stoperr_pdata", 32'(P_DATA), 32'h07);

      // Two-cycle glitch on the idle line, then a real 0x01 frame.
      snapshot();
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      repeat (2) @(negedge CLK);
      idle(30);
      checkOutput("glitch_pulses", 32'((dv_count - dv0) + (pe_count - pe0) + (se_count - se0)), 32'd0);
      applyStimulus(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(24);
      checkOutput("glitch_next_dv", 32'(dv_count - dv0), 32'd1);
      checkOutput("glitch_next_pdata", 32'(P_DATA), 32'h01);

      // Break: line held low for many frames gives a single stop error, then recovery.
      snapshot();
      RX_IN = 1'b0;
      repeat (12 * 8) @(negedge CLK);
      idle(40);
      checkOutput("break_se", 32'(se_count - se0), 32'd1);
      checkOutput("break_dv", 32'(dv_count - dv0), 32'd0);
      snapshot();
      applyStimulus(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(24);
      checkOutput("break_next_dv", 32'(dv_count - dv0), 32'd1);
      checkOutput("break_next_pdata", 32'(P_DATA), 32'h42);

      // Back-to-back 0xFF and 0x00, then reset in the middle of a third frame.
      snapshot();
      applyStimulus(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      sendBit(1'b0, 8);
      sendBit(1'b1, 8);
      sendBit(1'b0, 8);
      sendBit(1'b1, 8);
      sendBit(1'b0, 4);
      checkOutput("b2b_dv_count", 32'(dv_count - dv0), 32'd2);
      checkOutput("b2b_first", 32'(dv_log[dv0]), 32'hFF);
      checkOutput("b2b_second", 32'(dv_log[dv0 + 1]), 32'h00);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      checkOutput("midreset_pdata", 32'(P_DATA), 32'h0);
      checkOutput("midreset_flags", 32'({Data_Valid, Par_Err, Stop_Err}), 32'h0);
      RX_IN = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      idle(120);
      checkOutput("abort_pulses", 32'((dv_count - dv0) + (pe_count - pe0) + (se_count - se0)), 32'd2);
      checkOutput("abort_pdata", 32'(P_DATA), 32'h0);
      snapshot();
      applyStimulus(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(24);
      checkOutput("after_reset_dv", 32'(dv_count - dv0), 32'd1);
      checkOutput("after_reset_pdata", 32'(P_DATA), 32'h33);

      checkOutput("exclusive_pulses", 32'(conflict_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
